// File: rtl/rv32_pkg.sv
// Shared RV32I definitions: load/store mask encodings, LSU FSM states and
// the instruction-format one-hots used by the decoder.
package rv32_pkg;

    localparam logic [2:0] MASK_B  = 3'b000;
    localparam logic [2:0] MASK_H  = 3'b001;
    localparam logic [2:0] MASK_W  = 3'b010;
    localparam logic [2:0] MASK_BU = 3'b100;
    localparam logic [2:0] MASK_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [5:0] FMT_R = 6'b000001;
    localparam logic [5:0] FMT_I = 6'b000010;
    localparam logic [5:0] FMT_S = 6'b000100;
    localparam logic [5:0] FMT_B = 6'b001000;
    localparam logic [5:0] FMT_U = 6'b010000;
    localparam logic [5:0] FMT_J = 6'b100000;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for dmem_lsu: byte enables, replicated store data,
// misalignment detection and load extraction/extension.
// DMEM_MISALIGN_TRAP_EN selects flagging misaligned accesses instead of forcing alignment.
module dmem_lane_align
    import rv32_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  mask,
    input  logic        write,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata_word,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_lane,
    output logic        misaligned,
    output logic [31:0] rdata_ext
);

    logic       is_byte;
    logic       is_half;
    logic [1:0] lane;
    logic [31:0] rd_shift;

    always_comb begin
        is_byte    = 1'b0;
        is_half    = 1'b0;
        misaligned = 1'b0;
        lane       = addr_lo;
        case (mask)
            MASK_B, MASK_BU: is_byte = 1'b1;
            MASK_H, MASK_HU: is_half = 1'b1;
            default:         ;
        endcase
`ifdef DMEM_MISALIGN_TRAP_EN
        misaligned = (mask == 3'b011) || (mask == 3'b110) || (mask == 3'b111) ||
                     (write && mask[2]) ||
                     (is_half && addr_lo[0]) ||
                     (!is_byte && !is_half && (addr_lo != 2'b00));
`else
        // Misaligned and reserved-mask requests are folded onto the naturally aligned access
        if (is_half)
            lane = {addr_lo[1], 1'b0};
        else if (!is_byte)
            lane = 2'b00;
`endif
    end

    always_comb begin
        byte_en    = 4'b1111;
        wdata_lane = wdata;
        if (is_byte) begin
            byte_en    = 4'b0001 << lane;
            wdata_lane = {4{wdata[7:0]}};
        end else if (is_half) begin
            byte_en    = 4'b0011 << lane;
            wdata_lane = {2{wdata[15:0]}};
        end
    end

    always_comb begin
        rd_shift  = rdata_word >> {lane, 3'b000};
        rdata_ext = rd_shift;
        if (is_byte)
            rdata_ext = {{24{~mask[2] & rd_shift[7]}}, rd_shift[7:0]};
        else if (is_half)
            rdata_ext = {{16{~mask[2] & rd_shift[15]}}, rd_shift[15:0]};
        if (misaligned || write)
            rdata_ext = 32'h0;
    end

endmodule

// File: rtl/dmem_lsu.sv
// Data-memory responder: one request at a time, programmable access latency,
// byte-masked word storage. DMEM_MISALIGN_TRAP_EN enables the misalignment flag.
module dmem_lsu
    import rv32_pkg::*;
#(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_write,
    input  logic [2:0]  i_req_mask,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_misaligned
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int AW    = IDX_W + 2;
    localparam int CNT_W = $clog2(LATENCY) + 1;

    state_t           state;
    logic [CNT_W-1:0] count;

    logic          req_write;
    logic [2:0]    req_mask;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;

    logic [31:0] mem [DEPTH];
    logic [31:0] rd_word;
    logic [3:0]  byte_en;
    logic [31:0] wdata_lane;
    logic        misaligned;
    logic [31:0] rdata_ext;
    logic        access;
    logic        unused_addr_hi;

    // Addresses wrap modulo the storage size; the upper bits carry no meaning here
    assign unused_addr_hi = ^i_req_addr[31:AW];

    assign access  = (state == BUSY) && (count == '0);
    assign rd_word = mem[req_addr[AW-1:2]];

    dmem_lane_align u_align (
        .addr_lo    (req_addr[1:0]),
        .mask       (req_mask),
        .write      (req_write),
        .wdata      (req_wdata),
        .rdata_word (rd_word),
        .byte_en    (byte_en),
        .wdata_lane (wdata_lane),
        .misaligned (misaligned),
        .rdata_ext  (rdata_ext)
    );

    always_ff @(posedge i_clk) begin
        if (o_req_ready && i_req_valid) begin
            req_write <= i_req_write;
            req_mask  <= i_req_mask;
            req_addr  <= i_req_addr[AW-1:0];
            req_wdata <= i_req_wdata;
        end
    end

    // Write gating follows the FSM state, so a reset during BUSY drops the store
    always_ff @(posedge i_clk) begin
        if (access && req_write && !misaligned) begin
            for (int b = 0; b < 4; b++) begin
                if (byte_en[b])
                    mem[req_addr[AW-1:2]][8*b +: 8] <= wdata_lane[8*b +: 8];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state            <= IDLE;
            count            <= '0;
            o_req_ready      <= 1'b1;
            o_rsp_valid      <= 1'b0;
            o_rsp_rdata      <= 32'h0;
            o_rsp_misaligned <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        state       <= BUSY;
                        o_req_ready <= 1'b0;
                        count       <= CNT_W'(LATENCY - 1);
                    end
                end
                BUSY: begin
                    if (count == '0) begin
                        state            <= RESP;
                        o_rsp_valid      <= 1'b1;
                        o_rsp_rdata      <= rdata_ext;
                        o_rsp_misaligned <= misaligned;
                    end else begin
                        count <= count - 1'b1;
                    end
                end
                RESP: begin
                    if (i_rsp_ready) begin
                        state       <= IDLE;
                        o_rsp_valid <= 1'b0;
                        o_req_ready <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    o_req_ready <= 1'b1;
                    o_rsp_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed table-driven bench for dmem_lsu plus hand-written hold and reset sequences.
module tb_dmem_lsu;
    localparam int DEPTH = 1024;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [2:0]  req_mask;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_mis;

    int n_checks = 0;
    int n_fail   = 0;

    dmem_lsu #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_req_valid      (req_valid),
        .o_req_ready      (req_ready),
        .i_req_write      (req_write),
        .i_req_mask       (req_mask),
        .i_req_addr       (req_addr),
        .i_req_wdata      (req_wdata),
        .o_rsp_valid      (rsp_valid),
        .i_rsp_ready      (rsp_ready),
        .o_rsp_rdata      (rsp_rdata),
        .o_rsp_misaligned (rsp_mis)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [2:0]  mask;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_mis;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs[NV];

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [2:0] m, input logic [31:0] a,
                                input logic [31:0] wd, input logic [31:0] er, input logic em);
        vec_t v;
        v.wr = wr; v.mask = m; v.addr = a; v.wdata = wd; v.exp_rdata = er; v.exp_mis = em;
        return v;
    endfunction

    // Called at #1 after a rising edge with the DUT idle
    task automatic do_req(input logic wr, input logic [2:0] m, input logic [31:0] a,
                          input logic [31:0] wd, output logic [31:0] rd, output logic mis,
                          output int lat);
        int guard;
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(posedge clk); #1; guard++;
        end
        req_valid = 1'b1; req_write = wr; req_mask = m; req_addr = a; req_wdata = wd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        rd  = rsp_rdata;
        mis = rsp_mis;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        mis;
        int          lat;
        logic [31:0] w14_exp;
        logic [31:0] w10_exp;

        w10_exp = 32'h123480EF;
        w14_exp = TRAP ? 32'h11223344 : 32'h1122BEEF;

        vecs[0]  = mk(1, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        0);
        vecs[1]  = mk(0, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 0);
        vecs[2]  = mk(1, 3'b000, 32'h11,   32'h80,       32'h0,        0);
        vecs[3]  = mk(0, 3'b000, 32'h11,   32'h0,        32'hFFFFFF80, 0);
        vecs[4]  = mk(0, 3'b100, 32'h11,   32'h0,        32'h00000080, 0);
        vecs[5]  = mk(0, 3'b010, 32'h10,   32'h0,        32'hDEAD80EF, 0);
        vecs[6]  = mk(1, 3'b001, 32'h12,   32'h1234,     32'h0,        0);
        vecs[7]  = mk(0, 3'b001, 32'h12,   32'h0,        32'h00001234, 0);
        vecs[8]  = mk(0, 3'b010, 32'h10,   32'h0,        w10_exp,      0);
        vecs[9]  = mk(0, 3'b010, 32'h13,   32'h0,        TRAP ? 32'h0 : w10_exp, TRAP);
        vecs[10] = mk(0, 3'b010, 32'h10,   32'h0,        w10_exp,      0);
        vecs[11] = mk(0, 3'b101, 32'h10,   32'h0,        32'h000080EF, 0);
        vecs[12] = mk(0, 3'b001, 32'h10,   32'h0,        32'hFFFF80EF, 0);
        vecs[13] = mk(0, 3'b000, 32'h12,   32'h0,        32'h00000034, 0);
        vecs[14] = mk(1, 3'b010, 32'h14,   32'h11223344, 32'h0,        0);
        vecs[15] = mk(1, 3'b001, 32'h15,   32'hBEEF,     32'h0,        TRAP);
        vecs[16] = mk(0, 3'b010, 32'h14,   32'h0,        w14_exp,      0);
        vecs[17] = mk(0, 3'b010, 32'h1010, 32'h0,        w10_exp,      0);
        vecs[18] = mk(0, 3'b011, 32'h10,   32'h0,        TRAP ? 32'h0 : w10_exp, TRAP);
        vecs[19] = mk(1, 3'b010, 32'h20,   32'hCAFEF00D, 32'h0,        0);

        rst_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_mask = 3'b0;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_req_ready", {31'h0, req_ready}, 32'h1);
        check("reset_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("reset_rsp_rdata", rsp_rdata, 32'h0);
        check("reset_rsp_mis",   {31'h0, rsp_mis}, 32'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < NV; i++) begin
            do_req(vecs[i].wr, vecs[i].mask, vecs[i].addr, vecs[i].wdata, rd, mis, lat);
            check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("vec%0d_mis", i), {31'h0, mis}, {31'h0, vecs[i].exp_mis});
            check($sformatf("vec%0d_latency", i), lat, LAT);
        end

        // Response held for 5 cycles while a competing request is offered
        req_valid = 1'b1; req_write = 1'b0; req_mask = 3'b010; req_addr = 32'h10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
        check("hold_latency", lat, LAT);
        req_valid = 1'b1; req_write = 1'b1; req_mask = 3'b010; req_addr = 32'h10;
        req_wdata = 32'h0;
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("hold%0d_valid", c), {31'h0, rsp_valid}, 32'h1);
            check($sformatf("hold%0d_rdata", c), rsp_rdata, w10_exp);
            check($sformatf("hold%0d_ready", c), {31'h0, req_ready}, 32'h0);
        end
        req_valid = 1'b0;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        check("hold_release_valid", {31'h0, rsp_valid}, 32'h0);
        do_req(0, 3'b010, 32'h10, 32'h0, rd, mis, lat);
        check("hold_ignored_store", rd, w10_exp);

        // Load 0x20 so the response register holds nonzero data before the reset
        do_req(0, 3'b010, 32'h20, 32'h0, rd, mis, lat);
        check("pre_reset_load", rd, 32'hCAFEF00D);
        req_valid = 1'b1; req_write = 1'b1; req_mask = 3'b010; req_addr = 32'h20;
        req_wdata = 32'h55;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("busy_ready_low", {31'h0, req_ready}, 32'h0);
        rst_n = 1'b0;
        #1;
        check("midrst_req_ready", {31'h0, req_ready}, 32'h1);
        check("midrst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("midrst_rsp_rdata", rsp_rdata, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        do_req(0, 3'b010, 32'h20, 32'h0, rd, mis, lat);
        check("post_reset_load", rd, 32'hCAFEF00D);
        check("post_reset_latency", lat, LAT);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
